// File: rtl/mojo_serial_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between
// NUM_REQ block producers. A granted block is latched, optionally prefixed
// with a header byte carrying the requester ID, and sent one byte at a time.
// The requester gets an ack pulse on latch and a done pulse on the last byte.
module mojo_serial_tx_arbiter #(
    parameter int         NUM_REQ     = 2,
    parameter int         BLOCK_BYTES = 4,
    parameter int         HEADER_EN   = 1,
    parameter logic [7:0] HEADER_BASE = 8'hA0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_REQ-1:0]                          req,
    input  logic [NUM_REQ*BLOCK_BYTES*8-1:0]            block_in,
    output logic [NUM_REQ-1:0]                          ack,
    output logic [NUM_REQ-1:0]                          done,
    input  logic                                        tx_busy,
    output logic [7:0]                                  tx_data,
    output logic                                        new_tx_data,
    output logic                                        busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BLK_W = BLOCK_BYTES * 8;
    localparam int CNT_W = $clog2(BLOCK_BYTES + 2);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;          // bytes still to issue, header included
    logic [BLK_W-1:0] shreg;        // latched payload, next byte in [7:0]
    logic             hdr_pending;  // header byte not yet issued
    logic             holdoff;      // one-cycle gap covering UART busy rise
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  lo_id, hi_id, pick_id;
    logic             lo_hit, hi_hit, pick_valid;
    logic [BLK_W-1:0] pick_blk;
    logic             grant_fire, issue_fire, last_byte;
    logic [7:0]       next_byte;

    // Round-robin pick: first request above last_grant, else lowest request.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        lo_id  = '0;
        hi_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_hit = 1'b1;
                lo_id  = ID_W'(i);
            end
            if (req[i] && (i > int'(last_grant))) begin
                hi_hit = 1'b1;
                hi_id  = ID_W'(i);
            end
        end
        pick_valid = lo_hit;
        pick_id    = hi_hit ? hi_id : lo_id;
    end

    // Select the block slice of the picked requester.
    always_comb begin
        pick_blk = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == ID_W'(i)) pick_blk = block_in[i*BLK_W +: BLK_W];
        end
    end

    // Grant only once busy has fallen, so busy shows a low cycle between blocks.
    assign grant_fire = (state == S_IDLE) && !busy && pick_valid;
    assign issue_fire = (state == S_ISSUE) && !tx_busy && !holdoff;
    assign last_byte  = (cnt == CNT_W'(1));
    assign next_byte  = hdr_pending ? (HEADER_BASE | 8'(grant_id)) : shreg[7:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant_fire) state_next = S_ISSUE;
            S_ISSUE: if (issue_fire && last_byte) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: latch on grant, issue bytes, generate registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload register is reset too; it is small and a clean restart is cheap.
            ack         <= '0;
            done        <= '0;
            new_tx_data <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            cnt         <= '0;
            shreg       <= '0;
            hdr_pending <= 1'b0;
            holdoff     <= 1'b0;
        end else begin
            ack         <= '0;
            done        <= '0;
            new_tx_data <= 1'b0;
            holdoff     <= 1'b0;

            if (grant_fire) begin
                shreg       <= pick_blk;
                grant_id    <= pick_id;
                last_grant  <= pick_id;
                cnt         <= CNT_W'(BLOCK_BYTES + HEADER_EN);
                hdr_pending <= (HEADER_EN != 0);
                busy        <= 1'b1;
                for (int i = 0; i < NUM_REQ; i++) ack[i] <= (pick_id == ID_W'(i));
            end else if (state == S_IDLE) begin
                busy <= 1'b0;
            end

            if (issue_fire) begin
                tx_data     <= next_byte;
                new_tx_data <= 1'b1;
                holdoff     <= 1'b1;
                cnt         <= cnt - CNT_W'(1);
                if (hdr_pending) hdr_pending <= 1'b0;
                else             shreg       <= shreg >> 8;
                if (last_byte) begin
                    for (int i = 0; i < NUM_REQ; i++) done[i] <= (grant_id == ID_W'(i));
                end
            end
        end
    end

endmodule

// File: tb/tb_mojo_serial_tx_arbiter.sv
// Scoreboard bench for mojo_serial_tx_arbiter. Stimulus pushes expected acks
// and bytes into queues; a monitor pops them as the DUT presents them.
// A second, header-less single-byte instance covers the minimal block case.
module tb_mojo_serial_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance: 2 requesters, 4-byte blocks, header on.
    logic [1:0]  req_a;
    logic [63:0] block_a;
    logic        tx_busy_a = 1'b0;
    logic [1:0]  ack_a, done_a;
    logic [7:0]  tx_data_a;
    logic        new_tx_a, busy_a;
    logic [0:0]  grant_a;

    // Minimal instance: 2 requesters, 1-byte blocks, no header.
    logic [1:0]  req_b;
    logic [15:0] block_b;
    logic        tx_busy_b = 1'b0;
    logic [1:0]  ack_b, done_b;
    logic [7:0]  tx_data_b;
    logic        new_tx_b, busy_b;
    logic [0:0]  grant_b;

    mojo_serial_tx_arbiter #(
        .NUM_REQ(2), .BLOCK_BYTES(4), .HEADER_EN(1), .HEADER_BASE(8'hA0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .block_in(block_a),
        .ack(ack_a), .done(done_a), .tx_busy(tx_busy_a), .tx_data(tx_data_a),
        .new_tx_data(new_tx_a), .busy(busy_a), .grant_id(grant_a)
    );

    mojo_serial_tx_arbiter #(
        .NUM_REQ(2), .BLOCK_BYTES(1), .HEADER_EN(0), .HEADER_BASE(8'hA0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .block_in(block_b),
        .ack(ack_b), .done(done_b), .tx_busy(tx_busy_b), .tx_data(tx_data_b),
        .new_tx_data(new_tx_b), .busy(busy_b), .grant_id(grant_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic [7:0] data;
        logic       last;
        int         id;
    } exp_byte_t;

    exp_byte_t tx_q[$];
    int        ack_q[$];
    int        ack_cnt    = 0;
    int        strobe_cnt = 0;

    task automatic push_block(int id, logic [31:0] blk);
        ack_q.push_back(id);
        tx_q.push_back('{8'hA0 | 8'(id), 1'b0, id});
        for (int b = 0; b < 4; b++) tx_q.push_back('{blk[b*8 +: 8], (b == 3), id});
    endtask

    // Monitor: compare every ack and strobe of the main instance.
    exp_byte_t mon_e;
    int        mon_id;
    logic      prev_new = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack_a != 2'b00) begin
                ack_cnt++;
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack_a), 32'd0);
                end else begin
                    mon_id = ack_q.pop_front();
                    check("ack_onehot", 32'(ack_a), 32'(1 << mon_id));
                    check("ack_grant_id", 32'(grant_a), 32'(mon_id));
                end
            end
            if (new_tx_a) begin
                strobe_cnt++;
                check("strobe_back_to_back", 32'(prev_new), 32'd0);
                if (tx_q.size() == 0) begin
                    check("unexpected_strobe", 32'(new_tx_a), 32'd0);
                end else begin
                    mon_e = tx_q.pop_front();
                    check("tx_data", 32'(tx_data_a), 32'(mon_e.data));
                    check("done_with_strobe", 32'(done_a), mon_e.last ? 32'(1 << mon_e.id) : 32'd0);
                    check("strobe_grant_id", 32'(grant_a), 32'(mon_e.id));
                end
            end else if (done_a != 2'b00) begin
                check("stray_done", 32'(done_a), 32'd0);
            end
        end
        prev_new = new_tx_a;
    end

    // UART model: busy for 10 cycles starting the cycle after each strobe.
    bit uart_en     = 1'b0;
    int busy_left   = 0;
    int last_strobe = -1;
    always @(negedge clk) begin
        if (uart_en) begin
            if (new_tx_a) begin
                check("uart_strobe_while_busy", 32'(tx_busy_a), 32'd0);
                if (last_strobe >= 0) check("uart_gap", 32'(cyc - last_strobe), 32'd12);
                last_strobe = cyc;
            end
            if (busy_left > 0) begin
                tx_busy_a = 1'b1;
                busy_left--;
            end else begin
                tx_busy_a = 1'b0;
            end
            if (new_tx_a) busy_left = 10;
        end
    end

    task automatic wait_ack(int target, int budget, string name);
        int k = 0;
        while (ack_cnt < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, 32'(ack_cnt), 32'(target));
    endtask

    task automatic wait_strobes(int target, int budget, string name);
        int k = 0;
        while (strobe_cnt < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, 32'(strobe_cnt), 32'(target));
    endtask

    task automatic wait_drain(int budget, string name);
        int k = 0;
        while ((tx_q.size() + ack_q.size()) != 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, 32'(tx_q.size() + ack_q.size()), 32'd0);
    endtask

    task automatic check_a_zero(string tag);
        check({tag, "_ack"},   32'(ack_a),     32'd0);
        check({tag, "_done"},  32'(done_a),    32'd0);
        check({tag, "_new"},   32'(new_tx_a),  32'd0);
        check({tag, "_busy"},  32'(busy_a),    32'd0);
        check({tag, "_data"},  32'(tx_data_a), 32'd0);
        check({tag, "_grant"}, 32'(grant_a),   32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        rst_n   = 1'b1;
        req_a   = '0;
        block_a = '0;
        req_b   = '0;
        block_b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_a_zero("reset");
        check("reset_b_busy", 32'(busy_b), 32'd0);
        check("reset_b_data", 32'(tx_data_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: single block, exact cycle timing from the request cycle N.
        block_a[31:0] = 32'h44332211;
        push_block(0, 32'h44332211);
        req_a = 2'b01;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check("t1_ack", 32'(ack_a), (k == 1) ? 32'd1 : 32'd0);
            check("t1_strobe", 32'(new_tx_a), ((k % 2 == 0) && (k <= 10)) ? 32'd1 : 32'd0);
            check("t1_busy", 32'(busy_a), (k <= 10) ? 32'd1 : 32'd0);
            if (k == 10) check("t1_done", 32'(done_a), 32'd1);
            if (k == 11) req_a = 2'b00;
        end
        wait_drain(20, "t1_drain");

        // Test 4: header-less single-byte block.
        block_b[7:0] = 8'h5A;
        req_b = 2'b01;
        @(negedge clk);
        check("t4_ack", 32'(ack_b), 32'd1);
        check("t4_no_strobe_yet", 32'(new_tx_b), 32'd0);
        check("t4_busy", 32'(busy_b), 32'd1);
        req_b = 2'b00;
        @(negedge clk);
        check("t4_strobe", 32'(new_tx_b), 32'd1);
        check("t4_data", 32'(tx_data_b), 32'h5A);
        check("t4_done", 32'(done_b), 32'd1);
        @(negedge clk);
        check("t4_idle_strobe", 32'(new_tx_b), 32'd0);
        check("t4_idle_busy", 32'(busy_b), 32'd0);
        check("t4_idle_done", 32'(done_b), 32'd0);

        // Test 2: both requesting continuously after reset -> 0,1,0,1.
        pulse_reset();
        block_a = {32'h88776655, 32'h44332211};
        push_block(0, 32'h44332211);
        push_block(1, 32'h88776655);
        push_block(0, 32'h44332211);
        push_block(1, 32'h88776655);
        base  = ack_cnt;
        req_a = 2'b11;
        wait_ack(base + 4, 100, "t2_acks");
        req_a = 2'b00;
        wait_drain(40, "t2_drain");

        // Test 3: UART holds tx_busy for 10 cycles after each strobe.
        uart_en       = 1'b1;
        last_strobe   = -1;
        block_a[31:0] = 32'h0D0C0B0A;
        push_block(0, 32'h0D0C0B0A);
        base  = ack_cnt;
        req_a = 2'b01;
        wait_ack(base + 1, 10, "t3_ack");
        req_a = 2'b00;
        wait_drain(100, "t3_drain");
        repeat (12) @(negedge clk);
        uart_en = 1'b0;
        check("t3_uart_released", 32'(tx_busy_a), 32'd0);

        // Test 5: reset after the second byte; block restarts from header.
        block_a[31:0] = 32'h44332211;
        ack_q.push_back(0);
        tx_q.push_back('{8'hA0, 1'b0, 0});
        tx_q.push_back('{8'h11, 1'b0, 0});
        base  = strobe_cnt;
        req_a = 2'b01;
        wait_strobes(base + 2, 20, "t5_two_bytes");
        #2 rst_n = 1'b0;
        #1;
        check_a_zero("t5_reset");
        check("t5_sb_consumed", 32'(tx_q.size() + ack_q.size()), 32'd0);
        push_block(0, 32'h44332211);
        base = ack_cnt;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(base + 1, 10, "t5_regrant");
        req_a = 2'b00;
        wait_drain(30, "t5_drain");

        // Test 6: short req[1] pulse while busy; block_in changed after latch.
        block_a[31:0] = 32'hCAFEF00D;
        push_block(0, 32'hCAFEF00D);
        base  = ack_cnt;
        req_a = 2'b01;
        wait_ack(base + 1, 10, "t6_ack");
        req_a   = 2'b10;
        block_a = {32'h12345678, 32'hDEADBEEF};
        @(negedge clk); #1;
        req_a = 2'b00;
        wait_drain(30, "t6_drain");
        repeat (4) @(negedge clk);
        #1;
        check("t6_no_ack1", 32'(ack_cnt), 32'(base + 1));
        check("t6_idle_busy", 32'(busy_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
